// File: rtl/ula_multiciclo_pkg.sv
// Shared encodings for the multicycle ULA: ALUOp/func codes, FSM states,
// internal operation set and the ALUOp/func decoder.
package ula_multiciclo_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_XOR   = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_RTYPE = 3'b110;
  localparam logic [2:0] ALUOP_ADD2  = 3'b111;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_XOR   = 6'b100110;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLT,
    OP_MULTU,
    OP_DIVU,
    OP_MFHI,
    OP_MFLO
  } op_e;

  // Unknown func codes and unlisted ALUOp values fall back to add.
  function automatic op_e decode_op(input logic [2:0] aluop, input logic [5:0] fn);
    op_e op;
    op = OP_ADD;
    case (aluop)
      ALUOP_ADD, ALUOP_ADD2: op = OP_ADD;
      ALUOP_SUB:             op = OP_SUB;
      ALUOP_AND:             op = OP_AND;
      ALUOP_OR:              op = OP_OR;
      ALUOP_XOR:             op = OP_XOR;
      ALUOP_SLT:             op = OP_SLT;
      ALUOP_RTYPE: begin
        case (fn)
          FUNC_SUB:   op = OP_SUB;
          FUNC_AND:   op = OP_AND;
          FUNC_OR:    op = OP_OR;
          FUNC_XOR:   op = OP_XOR;
          FUNC_SLT:   op = OP_SLT;
          FUNC_MULTU: op = OP_MULTU;
          FUNC_DIVU:  op = OP_DIVU;
          FUNC_MFHI:  op = OP_MFHI;
          FUNC_MFLO:  op = OP_MFLO;
          default:    op = OP_ADD;
        endcase
      end
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ula_multiciclo_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// Loads on start, runs WIDTH iterations, then pulses done for one cycle
// with the final {hi_o, lo_o} held until the next start.
module ula_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, lo_q, opd_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             div_q, run_q, done_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum, shifted, diff;

  // One iteration step: shift-add for multu, trial subtract for divu.
  // Divide by zero needs no special case: every trial subtract succeeds,
  // giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, opd_q};
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opd_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (div_q) begin
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
    end else begin
      {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end
  end

  // Operand load, iteration counter and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
      div_q  <= 1'b0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        hi_q  <= '0;
        lo_q  <= is_div ? a : b;
        opd_q <= is_div ? b : a;
        div_q <= is_div;
        run_q <= 1'b1;
        cnt_q <= '0;
      end else if (run_q) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle ULA for the EX stage: ALUOp/func decode, single-cycle ALU ops,
// iterative multu/divu with HI/LO, valid/ready on both sides.
module ula_multiciclo
  import ula_multiciclo_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int OP_W   = 3,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   ALUOp,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              busy
);

  state_e           state_q, state_d;
  op_e              op_q, op_in;
  logic [WIDTH-1:0] a_q, b_q, result_q, hi_q, lo_q, alu_res;
  logic             zero_q;
  logic             accept, md_start, md_is_div, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign op_in     = decode_op(ALUOp[2:0], func[5:0]);
  assign accept    = in_valid && (state_q == S_IDLE);
  assign md_start  = accept && (op_in == OP_MULTU || op_in == OP_DIVU);
  assign md_is_div = (op_in == OP_DIVU);

  ula_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_is_div),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .hi_o   (md_hi),
    .lo_o   (md_lo)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (op_in == OP_MULTU)     state_d = S_MUL;
        else if (op_in == OP_DIVU) state_d = S_DIV;
        else                       state_d = S_EXEC;
      end
      S_EXEC:       state_d = S_DONE;
      S_MUL, S_DIV: if (md_done) state_d = S_DONE;
      S_DONE:       if (out_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Single-cycle ALU on the captured operands; mfhi/mflo read HI/LO, which
  // cannot change between accept and EXEC.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Operand capture on accept; result/zero/HI/LO update on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept) begin
        op_q <= op_in;
        a_q  <= a;
        b_q  <= b;
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
      end
      if ((state_q == S_MUL || state_q == S_DIV) && md_done) begin
        hi_q     <= md_hi;
        lo_q     <= md_lo;
        result_q <= md_lo;
        zero_q   <= (md_lo == '0);
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_EXEC) || (state_q == S_MUL) || (state_q == S_DIV);
  assign result    = result_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: the driver pushes reference-model
// expectations on accept, the monitor pops and checks on each output handshake.
module tb_ula_multiciclo;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [2:0]    ALUOp;
  logic [5:0]    func;
  logic [W-1:0]  a, b, result, hi, lo;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  bit          seen = 0;
  bit          rand_bp = 0;

  ula_multiciclo #(.WIDTH(W), .OP_W(3), .FUNC_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .func      (func),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: plain MIPS-style semantics with 64-bit product and
  // native / and %. Updates model HI/LO as a side effect.
  task automatic model(input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int lat);
    int          k;
    logic [63:0] p;
    // k: 0 add 1 sub 2 and 3 or 4 xor 5 slt 6 multu 7 divu 8 mfhi 9 mflo
    case (op)
      3'd1: k = 1;
      3'd2: k = 2;
      3'd3: k = 3;
      3'd4: k = 4;
      3'd5: k = 5;
      3'd6: case (fn)
        6'h22: k = 1;
        6'h24: k = 2;
        6'h25: k = 3;
        6'h26: k = 4;
        6'h2a: k = 5;
        6'h19: k = 6;
        6'h1b: k = 7;
        6'h10: k = 8;
        6'h12: k = 9;
        default: k = 0;
      endcase
      default: k = 0;
    endcase
    lat = 2;
    r = '0;
    case (k)
      0: r = x + y;
      1: r = x - y;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      6: begin
        p = {32'd0, x} * {32'd0, y};
        mhi = p[63:32];
        mlo = p[31:0];
        r = mlo;
        lat = W + 2;
      end
      7: begin
        if (y == 0) begin
          mlo = 32'hFFFF_FFFF;
          mhi = x;
        end else begin
          mlo = x / y;
          mhi = x % y;
        end
        r = mlo;
        lat = W + 2;
      end
      8: r = mhi;
      default: r = mlo;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   t;
    @(posedge clk);
    #1;
    ALUOp = op; func = fn; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    model(op, fn, x, y, e.res, e.lat);
    e.hi  = mhi;
    e.lo  = mlo;
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  // Monitor: checks latency on first sight of out_valid, result stability
  // and in_ready while held, full outputs on the handshake cycle.
  always @(negedge clk) begin
    if (reset !== 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        if (!seen) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output result=0x%0h required=none", result);
        end
        seen = 1;
        if (out_ready) seen = 0;
      end else begin
        if (!seen) begin
          seen = 1;
          chk("latency", 64'(cyc + 1 - q[0].acc), 64'(q[0].lat));
        end
        chk("result", result, q[0].res);
        chk("in_ready_in_done", in_ready, 1'b0);
        if (out_ready) begin
          chk("zero", zero, q[0].res == 0);
          chk("hi", hi, q[0].hi);
          chk("lo", lo, q[0].lo);
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) #1 out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk_reset_vals();
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [5:0]  fcodes [10];
    logic [31:0] edges [6];
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] x, y;
    int          t;
    fcodes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h19, 6'h1b, 6'h10, 6'h12};
    edges  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = '0; func = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals();
    @(negedge clk) reset = 1'b0;

    // sub via func, slt, ALUOp 111 add, zero on equal subtract
    issue(3'b110, 6'h22, 32'd5, 32'd7);
    issue(3'b101, 6'h00, 32'hFFFF_FFFF, 32'd1);
    issue(3'b111, 6'h00, 32'd2, 32'd3);
    issue(3'b001, 6'h00, 32'd9, 32'd9);
    // multu then mfhi / mflo
    issue(3'b110, 6'h19, 32'hFFFF_FFFF, 32'd2);
    issue(3'b110, 6'h10, 32'd0, 32'd0);
    issue(3'b110, 6'h12, 32'd0, 32'd0);
    // divu, including divide by zero
    issue(3'b110, 6'h1b, 32'd100, 32'd7);
    issue(3'b110, 6'h1b, 32'd7, 32'd0);
    issue(3'b110, 6'h10, 32'd0, 32'd0);
    // unknown func falls back to add
    issue(3'b110, 6'h3f, 32'd40, 32'd2);
    drain();

    // backpressure: result held in DONE, new requests ignored
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(3'b100, 6'h00, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
    t = 0;
    while (out_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; ALUOp = 3'b000; a = $urandom; b = $urandom;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset in the middle of a multu
    issue(3'b110, 6'h19, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_vals();
    q.delete();
    mhi = '0;
    mlo = '0;
    seen = 0;
    @(negedge clk) reset = 1'b0;
    issue(3'b110, 6'h10, 32'd0, 32'd0);
    issue(3'b000, 6'h00, 32'd11, 32'd22);
    drain();

    // randomized traffic with random consumer backpressure
    rand_bp = 1;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
      else fn = fcodes[$urandom_range(0, 9)];
      x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 5) == 0) y = 32'($urandom_range(0, 15));
      issue(op, fn, x, y);
    end
    rand_bp = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
